// File: rtl/spi_controller_param.sv
// Parametrised SPI master: one csb-framed write-then-read transaction per request.
// SPI mode and SCLK rate are fixed at elaboration through CPOL/CPHA/CLK_DIV.
module spi_controller_param #(
    parameter int TX_W    = 16,
    parameter int RX_W    = 24,
    parameter int CLK_DIV = 1,
    parameter int CPOL    = 0,
    parameter int CPHA    = 0,
    localparam int MAX_W  = (TX_W > RX_W) ? TX_W : RX_W,
    localparam int CW     = $clog2(MAX_W + 1)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            sclk,
    output logic            csb,
    output logic            mosi,
    input  logic            miso,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [TX_W-1:0] i_data,
    input  logic [CW-1:0]   i_tx_bits,
    input  logic [CW-1:0]   i_rx_bits,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [RX_W-1:0] o_data,
    output logic [CW-1:0]   bit_counter
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] TX_MAX = CW'(TX_W);
    localparam logic [CW-1:0] RX_MAX = CW'(RX_W);
    localparam logic POL = 1'(CPOL);
    localparam logic PHA = 1'(CPHA);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CS_SETUP = 3'd1,
        S_TXING    = 3'd2,
        S_RXING    = 3'd3,
        S_CS_HOLD  = 3'd4,
        S_DONE     = 3'd5,
        S_GAP      = 3'd6
    } state_t;

    state_t state, next_state;

    logic [DW-1:0]   div;
    logic            half;
    logic [TX_W-1:0] tx_data;
    logic [CW-1:0]   tx_n, rx_n;
    logic [CW-1:0]   tx_n_in, rx_n_in;
    logic [RX_W-1:0] rx_sr;
    logic            accept, tick, slot_end, timed, tx_bit;

    assign tx_n_in  = (i_tx_bits > TX_MAX) ? TX_MAX : i_tx_bits;
    assign rx_n_in  = (i_rx_bits > RX_MAX) ? RX_MAX : i_rx_bits;
    assign accept   = i_valid && (state == S_IDLE);
    assign tick     = (div == DIV_LAST);
    assign slot_end = tick && half;
    assign tx_bit   = |(tx_data & (TX_W'(1) << bit_counter));
    assign timed    = (state == S_CS_SETUP) || (state == S_TXING) ||
                      (state == S_RXING) || (state == S_CS_HOLD) ||
                      (state == S_GAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:
                if (i_valid)
                    next_state = (tx_n_in == '0 && rx_n_in == '0) ?
                                 S_DONE : S_CS_SETUP;
            S_CS_SETUP:
                if (tick)
                    next_state = (tx_n != '0) ? S_TXING :
                                 (rx_n != '0) ? S_RXING : S_CS_HOLD;
            S_TXING:
                if (slot_end && bit_counter == '0)
                    next_state = (rx_n != '0) ? S_RXING : S_CS_HOLD;
            S_RXING:
                if (slot_end && bit_counter == '0) next_state = S_CS_HOLD;
            S_CS_HOLD:
                if (tick) next_state = S_DONE;
            S_DONE:
                if (o_valid && o_ready) next_state = S_GAP;
            S_GAP:
                if (tick) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Each bit slot is two half-periods; half selects which one we are in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div  <= '0;
            half <= 1'b0;
        end else if (next_state != state || !timed) begin
            div  <= '0;
            half <= 1'b0;
        end else if (tick) begin
            div  <= '0;
            half <= ~half;
        end else begin
            div <= div + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_counter <= '0;
        end else if (accept) begin
            bit_counter <= (tx_n_in != '0) ? tx_n_in - CW'(1) : '0;
        end else if (state != S_RXING && next_state == S_RXING) begin
            bit_counter <= rx_n - CW'(1);
        end else if (state != S_TXING && next_state == S_TXING) begin
            bit_counter <= tx_n - CW'(1);
        end else if ((state == S_TXING || state == S_RXING) &&
                     slot_end && bit_counter != '0) begin
            bit_counter <= bit_counter - CW'(1);
        end
    end

    // Both modes sample miso in the middle of the bit slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data <= '0;
            tx_n    <= '0;
            rx_n    <= '0;
            rx_sr   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            if (accept) begin
                tx_data <= i_data;
                tx_n    <= tx_n_in;
                rx_n    <= rx_n_in;
                rx_sr   <= '0;
            end else if (state == S_RXING && tick && !half) begin
                rx_sr <= (rx_sr << 1) | RX_W'(miso);
            end
            if (state == S_DONE && !o_valid) begin
                o_valid <= 1'b1;
                o_data  <= rx_sr;
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        csb     = 1'b1;
        sclk    = POL;
        mosi    = 1'b0;
        i_ready = 1'b0;
        case (state)
            S_IDLE:     i_ready = 1'b1;
            S_CS_SETUP: begin
                csb  = 1'b0;
                mosi = !PHA && (tx_n != '0) && tx_bit;
            end
            S_TXING: begin
                csb  = 1'b0;
                sclk = POL ^ PHA ^ half;
                mosi = tx_bit;
            end
            S_RXING: begin
                csb  = 1'b0;
                sclk = POL ^ PHA ^ half;
            end
            S_CS_HOLD:  csb = 1'b0;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_spi_controller_param.sv
// Bench for spi_controller_param: mode-0/div-1 and mode-3/div-3 instances
// driven in turn, with a bit-level SPI slave model on the pins.
module tb_spi_controller_param;

    logic        clk, rst, miso, i_valid, o_ready, sel;
    logic [15:0] i_data;
    logic [4:0]  i_tx_bits, i_rx_bits;
    logic        sclk0, csb0, mosi0, rdy0, ov0;
    logic        sclk1, csb1, mosi1, rdy1, ov1;
    logic [23:0] od0, od1;
    logic [4:0]  bc0, bc1;
    logic        sclk_m, csb_m, mosi_m, rdy_m, ov_m, cpol_m, cpha_m;
    logic [23:0] od_m;

    int passed, total, cyc;
    int pulses, all_edges, csb_falls, hp_min, hp_max, last_cyc;
    bit have_last;
    bit mosi_q[$];
    bit slave_q[$];

    typedef struct {
        bit          s;
        int          txb;
        int          rxb;
        logic [15:0] d;
        logic [23:0] srx;
        logic [23:0] e_od;
        int          e_lat;
        logic [15:0] e_mosi;
        int          e_pulses;
    } vec_t;

    vec_t vecs[6];

    spi_controller_param u0 (
        .clk(clk), .rst(rst), .sclk(sclk0), .csb(csb0), .mosi(mosi0),
        .miso(miso), .i_valid(i_valid), .i_ready(rdy0), .i_data(i_data),
        .i_tx_bits(i_tx_bits), .i_rx_bits(i_rx_bits), .o_valid(ov0),
        .o_ready(o_ready), .o_data(od0), .bit_counter(bc0)
    );

    spi_controller_param #(
        .TX_W(16), .RX_W(24), .CLK_DIV(3), .CPOL(1), .CPHA(1)
    ) u1 (
        .clk(clk), .rst(rst), .sclk(sclk1), .csb(csb1), .mosi(mosi1),
        .miso(miso), .i_valid(i_valid), .i_ready(rdy1), .i_data(i_data),
        .i_tx_bits(i_tx_bits), .i_rx_bits(i_rx_bits), .o_valid(ov1),
        .o_ready(o_ready), .o_data(od1), .bit_counter(bc1)
    );

    assign sclk_m = sel ? sclk1 : sclk0;
    assign csb_m  = sel ? csb1  : csb0;
    assign mosi_m = sel ? mosi1 : mosi0;
    assign rdy_m  = sel ? rdy1  : rdy0;
    assign ov_m   = sel ? ov1   : ov0;
    assign od_m   = sel ? od1   : od0;
    assign cpol_m = sel;
    assign cpha_m = sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Slave: samples mosi on the sample edge, presents miso on the shift edge.
    always @(negedge csb_m) begin
        csb_falls = csb_falls + 1;
        have_last = 1'b0;
        if (!cpha_m) miso = (slave_q.size() > 0) ? slave_q.pop_front() : 1'b0;
    end

    always @(sclk_m) begin
        if (!csb_m) begin
            all_edges = all_edges + 1;
            if (sclk_m != cpol_m) pulses = pulses + 1;
            if (have_last) begin
                if (cyc - last_cyc < hp_min) hp_min = cyc - last_cyc;
                if (cyc - last_cyc > hp_max) hp_max = cyc - last_cyc;
            end
            last_cyc  = cyc;
            have_last = 1'b1;
            if ((sclk_m != cpol_m) != cpha_m)
                mosi_q.push_back(mosi_m);
            else
                miso = (slave_q.size() > 0) ? slave_q.pop_front() : 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clear_obs();
        mosi_q.delete();
        pulses    = 0;
        all_edges = 0;
        csb_falls = 0;
        hp_min    = 1000;
        hp_max    = 0;
        have_last = 1'b0;
    endtask

    task automatic do_txn(input string nm, input bit s, input int txb,
                          input int rxb, input logic [15:0] d,
                          input logic [23:0] srx, input logic [23:0] e_od,
                          input int e_lat, input logic [15:0] e_mosi,
                          input int e_pulses);
        int n, lat, dv, tn, rn, ones;
        logic [31:0] mv;
        bit got;
        sel = s;
        dv  = s ? 3 : 1;
        tn  = (txb > 16) ? 16 : txb;
        rn  = (rxb > 24) ? 24 : rxb;
        n = 0;
        @(negedge clk);
        while (!rdy_m && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ":idle"}, 32'(rdy_m), 1);
        slave_q.delete();
        for (int i = 0; i < tn; i++) slave_q.push_back(1'($urandom_range(0, 1)));
        for (int i = rn - 1; i >= 0; i--) slave_q.push_back(srx[i]);
        clear_obs();
        i_valid   = 1'b1;
        i_data    = d;
        i_tx_bits = 5'(txb);
        i_rx_bits = 5'(rxb);
        @(posedge clk);
        #1;
        i_valid   = 1'b0;
        i_data    = 16'($urandom);
        i_tx_bits = 5'($urandom);
        i_rx_bits = 5'($urandom);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 5000) begin
            @(posedge clk);
            lat++;
            #1;
            got = ov_m;
        end
        chk({nm, ":latency"}, 32'(lat), 32'(e_lat));
        chk({nm, ":o_data"}, 32'(od_m), 32'(e_od));
        chk({nm, ":mosi_len"}, 32'(mosi_q.size()), 32'(e_pulses));
        mv   = '0;
        ones = 0;
        for (int i = 0; i < mosi_q.size(); i++) begin
            if (i < tn) mv = (mv << 1) | 32'(mosi_q[i]);
            else ones += int'(mosi_q[i]);
        end
        chk({nm, ":mosi_bits"}, mv, 32'(e_mosi));
        chk({nm, ":mosi_rx_zero"}, 32'(ones), 0);
        chk({nm, ":pulses"}, 32'(pulses), 32'(e_pulses));
        chk({nm, ":csb_falls"}, 32'(csb_falls), (e_pulses > 0) ? 1 : 0);
        if (e_pulses > 0) begin
            chk({nm, ":half_min"}, 32'(hp_min), 32'(dv));
            chk({nm, ":half_max"}, 32'(hp_max), 32'(dv));
        end
        if (o_ready) begin
            n = 0;
            while (!rdy_m && n < 100) begin
                @(posedge clk);
                n++;
                #1;
            end
            chk({nm, ":ready_after_valid"}, 32'(n), 32'(dv + 1));
        end
    endtask

    initial begin
        int n, bad, tn, rn, dv, e_lat;
        bit s;
        int txb, rxb;
        logic [15:0] d;
        logic [23:0] srx, e_od;
        logic [15:0] e_mosi;

        vecs[0] = '{1'b0, 8,  0,  16'h00A5, 24'h0,      24'h0,      19,  16'h00A5, 8};
        vecs[1] = '{1'b0, 8,  16, 16'h000B, 24'hBEEF,   24'h00BEEF, 51,  16'h000B, 24};
        vecs[2] = '{1'b1, 16, 0,  16'h1234, 24'h0,      24'h0,      103, 16'h1234, 16};
        vecs[3] = '{1'b0, 0,  0,  16'hFFFF, 24'h7,      24'h0,      1,   16'h0,    0};
        vecs[4] = '{1'b0, 19, 4,  16'hC3A5, 24'h9,      24'h9,      43,  16'hC3A5, 20};
        vecs[5] = '{1'b1, 3,  24, 16'h0005, 24'hA5C3E1, 24'hA5C3E1, 169, 16'h0005, 27};

        passed = 0; total = 0; cyc = 0;
        sel = 1'b0; miso = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
        i_data = '0; i_tx_bits = '0; i_rx_bits = '0;
        clear_obs();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:csb0", 32'(csb0), 1);
        chk("rst:csb1", 32'(csb1), 1);
        chk("rst:sclk0", 32'(sclk0), 0);
        chk("rst:sclk1", 32'(sclk1), 1);
        chk("rst:mosi0", 32'(mosi0), 0);
        chk("rst:i_ready0", 32'(rdy0), 1);
        chk("rst:o_valid0", 32'(ov0), 0);
        chk("rst:o_data0", 32'(od0), 0);
        chk("rst:bit_counter0", 32'(bc0), 0);
        chk("rst:bit_counter1", 32'(bc1), 0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++)
            do_txn($sformatf("vec%0d", i), vecs[i].s, vecs[i].txb,
                   vecs[i].rxb, vecs[i].d, vecs[i].srx, vecs[i].e_od,
                   vecs[i].e_lat, vecs[i].e_mosi, vecs[i].e_pulses);

        // Consumer stall: result must hold until o_ready returns.
        o_ready = 1'b0;
        do_txn("stall", 1'b0, 8, 8, 16'h003C, 24'h5A, 24'h5A, 35, 16'h003C, 16);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov_m !== 1'b1 || od_m !== 24'h5A || rdy_m !== 1'b0 ||
                csb_m !== 1'b1) bad++;
        end
        chk("stall:hold", 32'(bad), 0);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall:release", 32'(ov_m), 0);

        // Reset at the 5th sclk edge of a 16-bit write.
        sel = 1'b0;
        n = 0;
        while (!rdy_m && n < 1000) begin
            @(negedge clk);
            n++;
        end
        slave_q.delete();
        clear_obs();
        i_valid = 1'b1; i_data = 16'hFFFF; i_tx_bits = 5'd16; i_rx_bits = 5'd0;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        n = 0;
        while (all_edges < 5 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort:edges_seen", 32'(all_edges >= 5), 1);
        rst = 1'b0;
        #1;
        chk("abort:csb", 32'(csb_m), 1);
        chk("abort:sclk", 32'(sclk_m), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (ov_m !== 1'b0) bad++;
        end
        chk("abort:no_valid", 32'(bad), 0);
        do_txn("post_abort", vecs[1].s, vecs[1].txb, vecs[1].rxb, vecs[1].d,
               vecs[1].srx, vecs[1].e_od, vecs[1].e_lat, vecs[1].e_mosi,
               vecs[1].e_pulses);

        // Random requests against an arithmetic reference model.
        for (int k = 0; k < 30; k++) begin
            s   = 1'($urandom_range(0, 1));
            txb = int'($urandom_range(0, 18));
            rxb = int'($urandom_range(0, 25));
            d   = 16'($urandom);
            srx = 24'($urandom);
            dv  = s ? 3 : 1;
            tn  = (txb < 16) ? txb : 16;
            rn  = (rxb < 24) ? rxb : 24;
            e_od   = 24'(srx & ((32'd1 << rn) - 32'd1));
            e_mosi = 16'(32'(d) & ((32'd1 << tn) - 32'd1));
            e_lat  = (tn + rn == 0) ? 1 : dv * (2 * (tn + rn) + 2) + 1;
            do_txn($sformatf("rnd%0d", k), s, txb, rxb, d, srx, e_od,
                   e_lat, e_mosi, tn + rn);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
